// File: rtl/tamarac_control.sv
// Control-unit FSM for the Tamarac CPU: sequences fetch, PC increment and execute
// micro-steps as one-hot bus-read / register-write strobes plus an ALU mode.
module tamarac_control #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [2:0]       opc,
    input  logic             acc_zero,
    output logic [1:0]       alucntl,
    output logic             rsw,
    output logic             rmem,
    output logic             rpc,
    output logic             racc,
    output logic             rir,
    output logic             rbuf,
    output logic             wmar,
    output logic             wmem,
    output logic             wpc,
    output logic             wacc,
    output logic             wir,
    output logic             warg,
    output logic             wbuf,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;
    localparam logic [1:0] ALU_INC = 2'b11;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_JUMP  = 3'b100;
    localparam logic [2:0] OP_JUMPZ = 3'b101;
    localparam logic [2:0] OP_COMP  = 3'b110;
    localparam logic [2:0] OP_IN    = 3'b111;

    // Operand-fetch E0 (rir,wmar) is shared by LOAD/STORE/ADD/AND; opc picks the E1 branch.
    localparam logic [3:0] S_F0   = 4'd0;
    localparam logic [3:0] S_F1   = 4'd1;
    localparam logic [3:0] S_F2   = 4'd2;
    localparam logic [3:0] S_F3   = 4'd3;
    localparam logic [3:0] S_MEM  = 4'd4;
    localparam logic [3:0] S_LD1  = 4'd5;
    localparam logic [3:0] S_ST1  = 4'd6;
    localparam logic [3:0] S_AL1  = 4'd7;
    localparam logic [3:0] S_AL2  = 4'd8;
    localparam logic [3:0] S_AL3  = 4'd9;
    localparam logic [3:0] S_JMP  = 4'd10;
    localparam logic [3:0] S_JMPZ = 4'd11;
    localparam logic [3:0] S_CMP0 = 4'd12;
    localparam logic [3:0] S_CMP1 = 4'd13;
    localparam logic [3:0] S_IN   = 4'd14;

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [CNT_W-1:0] instr_cnt_r;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_F0;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_cnt_r <= {CNT_W{1'b0}};
        end else if (instr_done) begin
            instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = S_F0;
        case (state_r)
            S_F0: begin
                if (run) begin
                    next_state_s = S_F1;
                end else begin
                    next_state_s = S_F0;
                end
            end
            S_F1: next_state_s = S_F2;
            S_F2: next_state_s = S_F3;
            S_F3: begin
                case (opc)
                    OP_LOAD, OP_STORE, OP_ADD, OP_AND: next_state_s = S_MEM;
                    OP_JUMP:  next_state_s = S_JMP;
                    OP_JUMPZ: next_state_s = S_JMPZ;
                    OP_COMP:  next_state_s = S_CMP0;
                    OP_IN:    next_state_s = S_IN;
                    default:  next_state_s = S_F0;
                endcase
            end
            S_MEM: begin
                case (opc)
                    OP_LOAD:         next_state_s = S_LD1;
                    OP_STORE:        next_state_s = S_ST1;
                    OP_ADD, OP_AND:  next_state_s = S_AL1;
                    default:         next_state_s = S_F0;
                endcase
            end
            S_AL1:   next_state_s = S_AL2;
            S_AL2:   next_state_s = S_AL3;
            S_CMP0:  next_state_s = S_CMP1;
            default: next_state_s = S_F0;
        endcase
    end

    // Strobe decode; everything is forced low while reset is held
    always_comb begin
        alucntl    = ALU_ADD;
        rsw        = 1'b0;
        rmem       = 1'b0;
        rpc        = 1'b0;
        racc       = 1'b0;
        rir        = 1'b0;
        rbuf       = 1'b0;
        wmar       = 1'b0;
        wmem       = 1'b0;
        wpc        = 1'b0;
        wacc       = 1'b0;
        wir        = 1'b0;
        warg       = 1'b0;
        wbuf       = 1'b0;
        instr_done = 1'b0;
        if (reset) begin
            instr_done = 1'b0;
        end else begin
            case (state_r)
                S_F0: begin
                    if (run) begin
                        rpc  = 1'b1;
                        wmar = 1'b1;
                    end else begin
                        rpc  = 1'b0;
                    end
                end
                S_F1: begin rmem = 1'b1; wir  = 1'b1; end
                S_F2: begin rpc  = 1'b1; wbuf = 1'b1; alucntl = ALU_INC; end
                S_F3: begin rbuf = 1'b1; wpc  = 1'b1; end
                S_MEM: begin rir = 1'b1; wmar = 1'b1; end
                S_LD1: begin rmem = 1'b1; wacc = 1'b1; instr_done = 1'b1; end
                S_ST1: begin racc = 1'b1; wmem = 1'b1; instr_done = 1'b1; end
                S_AL1: begin racc = 1'b1; warg = 1'b1; end
                S_AL2: begin
                    rmem = 1'b1;
                    wbuf = 1'b1;
                    if (opc == OP_AND) begin
                        alucntl = ALU_AND;
                    end else begin
                        alucntl = ALU_ADD;
                    end
                end
                S_AL3: begin rbuf = 1'b1; wacc = 1'b1; instr_done = 1'b1; end
                S_JMP: begin rir = 1'b1; wpc = 1'b1; instr_done = 1'b1; end
                S_JMPZ: begin
                    instr_done = 1'b1;
                    if (acc_zero) begin
                        rir = 1'b1;
                        wpc = 1'b1;
                    end else begin
                        rir = 1'b0;
                    end
                end
                S_CMP0: begin racc = 1'b1; wbuf = 1'b1; alucntl = ALU_NOT; end
                S_CMP1: begin rbuf = 1'b1; wacc = 1'b1; instr_done = 1'b1; end
                S_IN:   begin rsw  = 1'b1; wacc = 1'b1; instr_done = 1'b1; end
                default: begin instr_done = 1'b0; end
            endcase
        end
    end

    assign state     = state_r;
    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_tamarac_control.sv
// Bench for tamarac_control: a small datapath driven by the DUT strobes is compared
// against an instruction-level interpreter of the Tamarac ISA.
module tb_tamarac_control;

    logic        clock = 1'b0;
    logic        reset, run;
    logic [2:0]  opc;
    logic        acc_zero;
    logic [1:0]  alucntl;
    logic        rsw, rmem, rpc, racc, rir, rbuf;
    logic        wmar, wmem, wpc, wacc, wir, warg, wbuf;
    logic [3:0]  state;
    logic        instr_done;
    logic [15:0] instr_cnt;

    // Second instance with a 3-bit counter so wrap-around is reachable quickly.
    logic        reset2;
    logic [1:0]  alucntl2;
    logic        rsw2, rmem2, rpc2, racc2, rir2, rbuf2;
    logic        wmar2, wmem2, wpc2, wacc2, wir2, warg2, wbuf2;
    logic [3:0]  state2;
    logic        done2;
    logic [2:0]  cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    tamarac_control dut (
        .clock(clock), .reset(reset), .run(run), .opc(opc), .acc_zero(acc_zero),
        .alucntl(alucntl), .rsw(rsw), .rmem(rmem), .rpc(rpc), .racc(racc), .rir(rir),
        .rbuf(rbuf), .wmar(wmar), .wmem(wmem), .wpc(wpc), .wacc(wacc), .wir(wir),
        .warg(warg), .wbuf(wbuf), .state(state), .instr_done(instr_done),
        .instr_cnt(instr_cnt)
    );

    tamarac_control #(.CNT_W(3)) dut2 (
        .clock(clock), .reset(reset2), .run(1'b1), .opc(3'b111), .acc_zero(1'b0),
        .alucntl(alucntl2), .rsw(rsw2), .rmem(rmem2), .rpc(rpc2), .racc(racc2), .rir(rir2),
        .rbuf(rbuf2), .wmar(wmar2), .wmem(wmem2), .wpc(wpc2), .wacc(wacc2), .wir(wir2),
        .warg(warg2), .wbuf(wbuf2), .state(state2), .instr_done(done2),
        .instr_cnt(cnt2)
    );

    logic [14:0] svec, svec2;
    assign svec  = {alucntl, rsw, rmem, rpc, racc, rir, rbuf,
                    wmar, wmem, wpc, wacc, wir, warg, wbuf};
    assign svec2 = {alucntl2, rsw2, rmem2, rpc2, racc2, rir2, rbuf2,
                    wmar2, wmem2, wpc2, wacc2, wir2, warg2, wbuf2};

    // ---------------- datapath driven by the DUT strobes ----------------
    logic [15:0] mem [0:8191];
    logic [15:0] pc, acc, ir, dbuf, arg, leds, sw, bus, alu_out;
    logic [12:0] mar;
    logic        ld_en = 1'b0, acc_en = 1'b0;
    logic [12:0] ld_addr;
    logic [15:0] ld_data, acc_data;

    assign opc      = ir[15:13];
    assign acc_zero = (acc == 16'h0000);

    always_comb begin
        bus = 16'h0000;
        if (rsw)       bus = sw;
        else if (rmem) bus = mem[mar];
        else if (rpc)  bus = pc;
        else if (racc) bus = acc;
        else if (rir)  bus = {3'b000, ir[12:0]};
        else if (rbuf) bus = dbuf;
        else           bus = 16'h0000;
    end

    always_comb begin
        case (alucntl)
            2'b00:   alu_out = arg + bus;
            2'b01:   alu_out = arg & bus;
            2'b10:   alu_out = ~bus;
            default: alu_out = bus + 16'd1;
        endcase
    end

    always @(posedge clock) begin
        if (reset) begin
            pc <= 16'h0000;
        end else begin
            if (wmar) mar <= bus[12:0];
            if (wmem) begin
                mem[mar] <= bus;
                if (mar == 13'd8190) leds <= bus;
            end
            if (wpc)  pc   <= bus;
            if (wacc) acc  <= bus;
            if (wir)  ir   <= bus;
            if (warg) arg  <= bus;
            if (wbuf) dbuf <= alu_out;
        end
        if (ld_en)  mem[ld_addr] <= ld_data;
        if (acc_en) acc <= acc_data;
    end

    // ---------------- instruction-level reference model ----------------
    logic [15:0] m_mem [0:8191];
    logic [15:0] m_pc, m_acc, m_leds;
    int          m_cnt;

    task automatic model_step(output int cyc);
        logic [15:0] w;
        logic [12:0] a;
        w = m_mem[m_pc[12:0]];
        a = w[12:0];
        m_pc = m_pc + 16'd1;
        case (w[15:13])
            3'd0: begin m_acc = m_mem[a]; cyc = 6; end
            3'd1: begin
                m_mem[a] = m_acc;
                if (a == 13'd8190) m_leds = m_acc;
                cyc = 6;
            end
            3'd2: begin m_acc = m_acc + m_mem[a]; cyc = 8; end
            3'd3: begin m_acc = m_acc & m_mem[a]; cyc = 8; end
            3'd4: begin m_pc = {3'b000, a}; cyc = 5; end
            3'd5: begin if (m_acc == 16'h0000) m_pc = {3'b000, a}; cyc = 5; end
            3'd6: begin m_acc = ~m_acc; cyc = 6; end
            default: begin m_acc = sw; cyc = 5; end
        endcase
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [12:0] a, input logic [15:0] d);
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(posedge clock); #1;
        ld_en = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic poke_acc(input logic [15:0] d);
        acc_data = d; acc_en = 1'b1;
        @(posedge clock); #1;
        acc_en = 1'b0;
        m_acc = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", state, 4'd0);
        chk("rst_strobes", svec, 15'h0000);
        chk("rst_done", instr_done, 1'b0);
        chk("rst_cnt", instr_cnt, 16'h0000);
        m_pc  = 16'h0000;
        m_cnt = 0;
    endtask

    task automatic start();
        reset = 1'b0;
        @(posedge clock); #1;
        run = 1'b1;
    endtask

    // Runs one instruction from F0; optionally drops run on the given cycle.
    task automatic run_instr(input int drop_at);
        int cyc, exp_cyc;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            chk("one_r", ($countones({rsw, rmem, rpc, racc, rir, rbuf}) <= 1), 1'b1);
            if (cyc == drop_at) run = 1'b0;
        end while (!instr_done && cyc < 20);
        chk("done_seen", instr_done, 1'b1);
        model_step(exp_cyc);
        chk("cycles", cyc, exp_cyc);
        @(posedge clock); #1;
        chk("acc", acc, m_acc);
        chk("pc", pc, m_pc);
        chk("cnt", instr_cnt, m_cnt[15:0]);
    endtask

    initial begin
        int n;
        logic [12:0] a;
        logic [2:0]  op;
        reset  = 1'b1;
        reset2 = 1'b1;
        run    = 1'b0;
        sw     = 16'h0000;

        // LOAD 5
        do_reset();
        poke(13'd0, 16'h0005);
        poke(13'd5, 16'h1234);
        poke_acc(16'h0000);
        start();
        run_instr(0);
        chk("load_acc", acc, 16'h1234);
        chk("load_pc", pc, 16'h0001);

        // ADD 9
        do_reset();
        poke(13'd0, 16'h4009);
        poke(13'd9, 16'h0004);
        poke_acc(16'h0003);
        start();
        run_instr(0);
        chk("add_acc", acc, 16'h0007);

        // JUMPZ taken and not taken
        do_reset();
        poke(13'd0, 16'hA010);
        poke_acc(16'h0000);
        start();
        run_instr(0);
        chk("jz_taken_pc", pc, 16'h0010);
        do_reset();
        poke_acc(16'h0001);
        start();
        run_instr(0);
        chk("jz_not_pc", pc, 16'h0001);

        // COMP, IN, STORE to 8190
        do_reset();
        poke(13'd0, 16'hC000);
        poke(13'd1, 16'hE000);
        poke(13'd2, 16'h3FFE);
        poke_acc(16'h00FF);
        sw = 16'hA5A5;
        start();
        run_instr(0);
        chk("comp_acc", acc, 16'hFF00);
        run_instr(0);
        chk("in_acc", acc, 16'hA5A5);
        run_instr(0);
        chk("store_leds", leds, 16'hA5A5);

        // Drop run in E1 of ADD: completes, parks, then resumes
        do_reset();
        poke(13'd0, 16'h4009);
        poke(13'd1, 16'h4009);
        poke(13'd9, 16'h0004);
        poke_acc(16'h0003);
        start();
        run_instr(6);
        repeat (3) begin
            @(negedge clock);
            chk("halt_state", state, 4'd0);
            chk("halt_strobes", svec, 15'h0000);
            chk("halt_done", instr_done, 1'b0);
        end
        @(posedge clock); #1;
        chk("halt_pc", pc, 16'h0001);
        run = 1'b1;
        run_instr(0);
        chk("resume_acc", acc, 16'h000B);

        // Reset during E2 of ADD
        do_reset();
        poke(13'd0, 16'hE000);
        poke(13'd1, 16'h4009);
        poke(13'd9, 16'h0004);
        poke_acc(16'h0000);
        sw = 16'h0003;
        start();
        run_instr(0);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_strobes", svec, 15'h0000);
        chk("abort_wacc", wacc, 1'b0);
        chk("abort_done", instr_done, 1'b0);
        @(posedge clock); #1;
        chk("abort_state", state, 4'd0);
        chk("abort_cnt", instr_cnt, 16'h0000);
        chk("abort_acc", acc, 16'h0003);

        // Counter wrap on the narrow instance running IN back to back
        @(negedge clock);
        reset2 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!done2 && n < 10);
            chk("wrap_done", done2, 1'b1);
            chk("wrap_strobes", svec2, 15'h1008);
            chk("wrap_state_nz", (state2 != 4'd0), 1'b1);
            @(posedge clock); #1;
            chk("wrap_cnt", cnt2, k % 8);
        end
        reset2 = 1'b1;

        // Random programs
        for (int p = 0; p < 3; p++) begin
            do_reset();
            for (int i = 0; i < 128; i++) begin
                op = 3'($urandom_range(0, 7));
                a  = 13'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) poke(13'(i), 16'h0000);
                else                           poke(13'(i), {op, a});
            end
            poke_acc(16'($urandom));
            start();
            repeat (40) begin
                sw = 16'($urandom);
                run_instr(0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
